// File: rtl/gemm_pkg.sv
// ============================================================================
// Module   : gemm_pkg
// Purpose  : Shared types and constants for the GEMM tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gemm_pkg;

    localparam int unsigned TILE_DEFAULT = 8;
    localparam int unsigned DIM_W        = 16;

    typedef enum logic [1:0] {
        OS = 2'd0,
        WS = 2'd1
    } dataflow_e;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Extent of a tile starting at org along a dimension of size dim.
    function automatic logic [DIM_W-1:0] clip_len(input logic [DIM_W-1:0] dim,
                                                  input logic [DIM_W-1:0] org,
                                                  input logic [DIM_W-1:0] tile);
        logic [DIM_W-1:0] rem;
        rem = dim - org;
        return (rem < tile) ? rem : tile;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gemm_tile_iter.sv
// ============================================================================
// Module   : gemm_tile_iter
// Purpose  : Three-level tile origin/extent iterator (m,n,k or n,k,m order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_tile_iter
    import gemm_pkg::*;
#(
    parameter int TILE = TILE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   advance,
    input  logic                   n_outer,
    input  logic [DIM_W-1:0]       dim_m,
    input  logic [DIM_W-1:0]       dim_n,
    input  logic [DIM_W-1:0]       dim_k,
    output logic [DIM_W-1:0]       m0,
    output logic [DIM_W-1:0]       n0,
    output logic [DIM_W-1:0]       k0,
    output logic [$clog2(TILE):0]  mlen,
    output logic [$clog2(TILE):0]  nlen,
    output logic [$clog2(TILE):0]  klen,
    output logic                   last
);

    localparam int               LW     = $clog2(TILE) + 1;
    localparam logic [DIM_W-1:0] TILE_D = DIM_W'(TILE);

    logic [DIM_W-1:0] m0_q, m0_d, n0_q, n0_d, k0_q, k0_d;
    logic             m_last, n_last, k_last;

    // 17-bit sums so an origin near 64K cannot wrap and look "not last".
    assign m_last = ({1'b0, m0_q} + 17'(TILE)) >= {1'b0, dim_m};
    assign n_last = ({1'b0, n0_q} + 17'(TILE)) >= {1'b0, dim_n};
    assign k_last = ({1'b0, k0_q} + 17'(TILE)) >= {1'b0, dim_k};

    always_comb begin
        m0_d = m0_q;
        n0_d = n0_q;
        k0_d = k0_q;
        if (load) begin
            m0_d = '0;
            n0_d = '0;
            k0_d = '0;
        end else if (advance) begin
            if (n_outer) begin
                if (!m_last) begin
                    m0_d = m0_q + TILE_D;
                end else begin
                    m0_d = '0;
                    if (!k_last) begin
                        k0_d = k0_q + TILE_D;
                    end else begin
                        k0_d = '0;
                        n0_d = n0_q + TILE_D;
                    end
                end
            end else begin
                if (!k_last) begin
                    k0_d = k0_q + TILE_D;
                end else begin
                    k0_d = '0;
                    if (!n_last) begin
                        n0_d = n0_q + TILE_D;
                    end else begin
                        n0_d = '0;
                        m0_d = m0_q + TILE_D;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_q <= '0;
            n0_q <= '0;
            k0_q <= '0;
        end else begin
            m0_q <= m0_d;
            n0_q <= n0_d;
            k0_q <= k0_d;
        end
    end

    assign m0   = m0_q;
    assign n0   = n0_q;
    assign k0   = k0_q;
    assign mlen = LW'(clip_len(dim_m, m0_q, TILE_D));
    assign nlen = LW'(clip_len(dim_n, n0_q, TILE_D));
    assign klen = LW'(clip_len(dim_k, k0_q, TILE_D));
    assign last = m_last && n_last && k_last;

endmodule

`default_nettype wire

// File: rtl/gemm_tile_sched.sv
// ============================================================================
// Module   : gemm_tile_sched
// Purpose  : GEMM job scheduler issuing tile commands with outstanding limit.
//            Define GEMM_SCHED_PERF_EN to build the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_tile_sched
    import gemm_pkg::*;
#(
    parameter int TILE    = TILE_DEFAULT,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            m,
    input  logic [15:0]            n,
    input  logic [15:0]            k,
    input  logic [1:0]             dataflow,
    input  logic [1:0]             fmt,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [15:0]            cmd_m0,
    output logic [15:0]            cmd_n0,
    output logic [15:0]            cmd_k0,
    output logic [$clog2(TILE):0]  cmd_mlen,
    output logic [$clog2(TILE):0]  cmd_nlen,
    output logic [$clog2(TILE):0]  cmd_klen,
    output logic                   cmd_first_k,
    output logic                   cmd_last_k,
    output logic [1:0]             cmd_fmt,
    input  logic                   tile_done,
    output logic [31:0]            cycles,
    output logic [31:0]            active,
    output logic [31:0]            stalls
);

    localparam int LW = $clog2(TILE) + 1;

    state_e      state_q, state_d;
    logic [15:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic [1:0]  df_q, df_d, fmt_q, fmt_d;
    logic        done_q, done_d;
    logic [3:0]  out_q, out_d;
    logic        load, hs, td_eff, issue;

    logic [15:0]   it_m0, it_n0, it_k0;
    logic [LW-1:0] it_mlen, it_nlen, it_klen;
    logic          it_last;

    gemm_tile_iter #(.TILE(TILE)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (hs),
        .n_outer (df_q == 2'(WS)),
        .dim_m   (m_q),
        .dim_n   (n_q),
        .dim_k   (k_q),
        .m0      (it_m0),
        .n0      (it_n0),
        .k0      (it_k0),
        .mlen    (it_mlen),
        .nlen    (it_nlen),
        .klen    (it_klen),
        .last    (it_last)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        df_d    = df_q;
        fmt_d   = fmt_q;
        done_d  = done_q;
        load    = 1'b0;

        issue     = (state_q == ISSUE);
        cmd_valid = issue && (out_q < 4'(MAX_OUT));
        hs        = cmd_valid && cmd_ready;
        td_eff    = tile_done && (out_q != '0);

        // A handshake and a retirement in the same cycle cancel out.
        out_d = out_q;
        if (hs && !td_eff) begin
            out_d = out_q + 4'd1;
        end else if (!hs && td_eff) begin
            out_d = out_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (m != '0 && n != '0 && k != '0) begin
                        m_d     = m;
                        n_d     = n;
                        k_d     = k;
                        df_d    = dataflow;
                        fmt_d   = fmt;
                        done_d  = 1'b0;
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (hs && it_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Payload is forced to zero outside ISSUE so reset/idle show a clean bus.
        cmd_m0      = issue ? it_m0   : '0;
        cmd_n0      = issue ? it_n0   : '0;
        cmd_k0      = issue ? it_k0   : '0;
        cmd_mlen    = issue ? it_mlen : '0;
        cmd_nlen    = issue ? it_nlen : '0;
        cmd_klen    = issue ? it_klen : '0;
        cmd_first_k = issue && (it_k0 == '0);
        cmd_last_k  = issue && (({1'b0, it_k0} + 17'(it_klen)) == {1'b0, k_q});
        cmd_fmt     = issue ? fmt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            df_q    <= '0;
            fmt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            df_q    <= df_d;
            fmt_q   <= fmt_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] cycles_q, cycles_d, active_q, active_d, stalls_q, stalls_d;
    logic        cnt_clr;

    always_comb begin
        cnt_clr  = (state_q == IDLE) && start;
        cycles_d = cycles_q;
        active_d = active_q;
        stalls_d = stalls_q;
        if (cnt_clr) begin
            cycles_d = '0;
            active_d = '0;
            stalls_d = '0;
        end else begin
            if (busy && cycles_q != '1)                  cycles_d = cycles_q + 32'd1;
            if (out_q != '0 && active_q != '1)           active_d = active_q + 32'd1;
            if (cmd_valid && !cmd_ready && stalls_q != '1) stalls_d = stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q <= '0;
            active_q <= '0;
            stalls_q <= '0;
        end else begin
            cycles_q <= cycles_d;
            active_q <= active_d;
            stalls_q <= stalls_d;
        end
    end

    assign cycles = cycles_q;
    assign active = active_q;
    assign stalls = stalls_q;
`else
    assign cycles = '0;
    assign active = '0;
    assign stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_sched.sv
// ============================================================================
// Module   : tb_gemm_tile_sched
// Purpose  : Self-checking bench: job-level reference model plus directed and
//            random jobs (TILE=8, MAX_OUT=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_tile_sched;

    localparam int TILE    = 8;
    localparam int MAX_OUT = 2;
    localparam int LW      = $clog2(TILE) + 1;
`ifdef GEMM_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [15:0]   m0;
        logic [15:0]   n0;
        logic [15:0]   k0;
        logic [LW-1:0] ml;
        logic [LW-1:0] nl;
        logic [LW-1:0] kl;
        logic          fk;
        logic          lk;
        logic [1:0]    fm;
    } cmd_t;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0]   m = '0, n = '0, k = '0;
    logic [1:0]    dataflow = '0, fmt = '0;
    logic          busy, done, cmd_valid;
    logic          cmd_ready = 1'b0, tile_done = 1'b0;
    logic [15:0]   cmd_m0, cmd_n0, cmd_k0;
    logic [LW-1:0] cmd_mlen, cmd_nlen, cmd_klen;
    logic          cmd_first_k, cmd_last_k;
    logic [1:0]    cmd_fmt;
    logic [31:0]   cycles, active, stalls;
    cmd_t          pay;

    gemm_tile_sched #(.TILE(TILE), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n), .k(k),
        .dataflow(dataflow), .fmt(fmt), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m0(cmd_m0), .cmd_n0(cmd_n0), .cmd_k0(cmd_k0),
        .cmd_mlen(cmd_mlen), .cmd_nlen(cmd_nlen), .cmd_klen(cmd_klen),
        .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k), .cmd_fmt(cmd_fmt),
        .tile_done(tile_done), .cycles(cycles), .active(active), .stalls(stalls)
    );

    always #5 clk = ~clk;
    always_comb pay = {cmd_m0, cmd_n0, cmd_k0, cmd_mlen, cmd_nlen, cmd_klen,
                       cmd_first_k, cmd_last_k, cmd_fmt};

    int     n_chk = 0, n_err = 0, cyc = 0;
    bit     chk_en = 1'b0;
    // Reference model: phase 0 idle, 1 issuing, 2 draining.
    int     ph = 0, e_out = 0, idx = 0;
    bit     e_done = 1'b0;
    longint e_cyc = 0, e_act = 0, e_stl = 0;
    cmd_t   job[$];
    cmd_t   dlog[$];
    int     pend[$];
    // Stimulus controls.
    bit     rdy_rand = 1'b0, rdy_fix = 1'b1, td_manual = 1'b0;
    int     td_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input int m0, n0, k0, dm, dn, dk, input logic [1:0] f);
        cmd_t c;
        int ml, nl, kl;
        ml = (dm - m0 < TILE) ? dm - m0 : TILE;
        nl = (dn - n0 < TILE) ? dn - n0 : TILE;
        kl = (dk - k0 < TILE) ? dk - k0 : TILE;
        c.m0 = 16'(m0); c.n0 = 16'(n0); c.k0 = 16'(k0);
        c.ml = LW'(ml); c.nl = LW'(nl); c.kl = LW'(kl);
        c.fk = (k0 == 0);
        c.lk = (k0 + kl == dk);
        c.fm = f;
        return c;
    endfunction

    task automatic build(input int dm, dn, dk, df, input logic [1:0] f);
        job.delete();
        if (df == 1) begin
            for (int a = 0; a < dn; a += TILE)
                for (int b = 0; b < dk; b += TILE)
                    for (int c = 0; c < dm; c += TILE)
                        job.push_back(mk(c, a, b, dm, dn, dk, f));
        end else begin
            for (int a = 0; a < dm; a += TILE)
                for (int b = 0; b < dn; b += TILE)
                    for (int c = 0; c < dk; c += TILE)
                        job.push_back(mk(a, b, c, dm, dn, dk, f));
        end
    endtask

    // Model update on every rising edge from the inputs the DUT samples.
    initial forever begin
        bit ev, hs, td;
        int old;
        @(posedge clk);
        cyc++;
        ev = (ph == 1) && (e_out < MAX_OUT);
        hs = ev && cmd_ready;
        td = tile_done && (e_out > 0);
        if (!rst_n) begin
            ph = 0; e_out = 0; idx = 0; e_done = 1'b0;
            e_cyc = 0; e_act = 0; e_stl = 0;
            chk_en = 1'b1;
        end else begin
            if (ph != 0 && e_cyc < 64'hFFFFFFFF) e_cyc++;
            if (e_out > 0 && e_act < 64'hFFFFFFFF) e_act++;
            if (ev && !cmd_ready && e_stl < 64'hFFFFFFFF) e_stl++;
            if (hs && td_mode == 1) pend.push_back(cyc + 3);
            e_out = e_out + int'(hs) - int'(td);
            old = ph;
            case (old)
                0: if (start) begin
                    e_cyc = 0; e_act = 0; e_stl = 0;
                    if (m != 0 && n != 0 && k != 0) begin
                        build(int'(m), int'(n), int'(k), int'(dataflow), fmt);
                        idx = 0; ph = 1; e_done = 1'b0;
                    end else begin
                        e_done = 1'b1;
                    end
                end
                1: if (hs) begin
                    idx++;
                    if (idx == job.size()) ph = 2;
                end
                2: if (e_out == 0) begin
                    ph = 0; e_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Compare process: every falling edge, outputs against the model.
    initial forever begin
        bit ev;
        @(negedge clk);
        if (chk_en) begin
            ev = (ph == 1) && (e_out < MAX_OUT);
            chk("busy", 64'(busy), 64'(ph != 0));
            chk("done", 64'(done), 64'(e_done));
            chk("cmd_valid", 64'(cmd_valid), 64'(ev));
            if (ev) chk("cmd_payload", 64'(pay), 64'(job[idx]));
            chk("cycles", 64'(cycles), PERF ? e_cyc : 64'd0);
            chk("active", 64'(active), PERF ? e_act : 64'd0);
            chk("stalls", 64'(stalls), PERF ? e_stl : 64'd0);
            if (cmd_valid && cmd_ready) dlog.push_back(pay);
        end
    end

    // Core/consumer emulation: ready and tile_done, driven after each edge.
    initial forever begin
        @(posedge clk);
        #2;
        cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
        tile_done = 1'b0;
        if (td_mode == 1) begin
            if (pend.size() > 0 && pend[0] <= cyc + 1) begin
                tile_done = 1'b1;
                void'(pend.pop_front());
            end
        end else if (td_mode == 2) begin
            tile_done = ($urandom_range(0, 2) == 0);
        end
        tile_done = tile_done | td_manual;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int c = 1);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int dm, dn, dk, df, f);
        m = 16'(dm); n = 16'(dn); k = 16'(dk);
        dataflow = 2'(df); fmt = 2'(f);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int i = 0;
        while (!(done && !busy) && i < lim) begin
            tick(1);
            i++;
        end
        chk("job_done_in_time", 64'(i < lim), 64'd1);
    endtask

    initial begin
        tick(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_payload", 64'(pay), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // 16x16x16, m/n/k order, tile_done three cycles after each issue.
        td_mode = 1; rdy_fix = 1'b1; dlog.delete();
        pulse_start(16, 16, 16, 0, 0);
        wait_done(400);
        chk("A_count", 64'(dlog.size()), 64'd8);
        if (dlog.size() == 8) begin
            chk("A_t0", 64'(dlog[0]), 64'(cmd_t'{16'd0, 16'd0, 16'd0, 4'd8, 4'd8, 4'd8, 1'b1, 1'b0, 2'd0}));
            chk("A_t1_k0", 64'(dlog[1].k0), 64'd8);
            chk("A_t2_n0", 64'(dlog[2].n0), 64'd8);
            chk("A_t4_m0", 64'(dlog[4].m0), 64'd8);
        end
        chk("A_busy", 64'(busy), 64'd0);
        chk("A_done", 64'(done), 64'd1);

        // Ragged m and a single short k step.
        dlog.delete();
        pulse_start(10, 8, 3, 0, 1);
        wait_done(400);
        chk("B_count", 64'(dlog.size()), 64'd2);
        if (dlog.size() == 2) begin
            chk("B_mlen0", 64'(dlog[0].ml), 64'd8);
            chk("B_mlen1", 64'(dlog[1].ml), 64'd2);
            chk("B_klen", 64'({dlog[0].kl, dlog[1].kl}), 64'h33);
            chk("B_first_last", 64'({dlog[0].fk, dlog[0].lk, dlog[1].fk, dlog[1].lk}), 64'hF);
            chk("B_fmt", 64'(dlog[1].fm), 64'd1);
        end

        // Zero dimension: no command, done right away.
        dlog.delete();
        pulse_start(0, 4, 4, 0, 0);
        chk("C_done", 64'(done), 64'd1);
        chk("C_busy", 64'(busy), 64'd0);
        tick(3);
        chk("C_no_cmd", 64'(dlog.size()), 64'd0);
        chk("C_cycles", 64'(cycles), 64'd0);

        // First command back-pressured for five cycles.
        rdy_fix = 1'b0; dlog.delete();
        tick(1);
        pulse_start(8, 8, 8, 0, 0);
        tick(5);
        rdy_fix = 1'b1;
        wait_done(200);
        chk("D_count", 64'(dlog.size()), 64'd1);
        chk("D_stalls", 64'(stalls), PERF ? 64'd5 : 64'd0);

        // Outstanding limit with tile_done withheld.
        td_mode = 0; pend.delete(); dlog.delete();
        pulse_start(16, 16, 16, 1, 2);
        tick(20);
        chk("E_count_at_limit", 64'(dlog.size()), 64'd2);
        chk("E_valid_low", 64'(cmd_valid), 64'd0);
        td_manual = 1'b1; tick(1); td_manual = 1'b0;
        tick(3);
        chk("E_count_after_retire", 64'(dlog.size()), 64'd3);
        td_mode = 2;
        wait_done(1000);

        // Start during a job is ignored; reset mid-issue abandons the job.
        td_mode = 1; pend.delete(); dlog.delete();
        pulse_start(16, 16, 16, 0, 0);
        tick(3);
        pulse_start(4, 4, 4, 1, 1);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("F_rst_busy", 64'(busy), 64'd0);
        chk("F_rst_done", 64'(done), 64'd0);
        chk("F_rst_valid", 64'(cmd_valid), 64'd0);
        chk("F_rst_payload", 64'(pay), 64'd0);
        chk("F_rst_cycles", 64'(cycles), 64'd0);
        rst_n = 1'b1;
        dlog.delete();
        tick(6);
        chk("F_no_cmd_after_rst", 64'(dlog.size()), 64'd0);
        pend.delete();
        pulse_start(12, 12, 12, 1, 3);
        wait_done(400);
        chk("F_count", 64'(dlog.size()), 64'd8);
        if (dlog.size() == 8) begin
            chk("F_t1_m0", 64'(dlog[1].m0), 64'd8);
            chk("F_t2_k0", 64'(dlog[2].k0), 64'd8);
            chk("F_t4_n0", 64'(dlog[4].n0), 64'd8);
        end

        // Random jobs, random back-pressure and retirement.
        td_mode = 2; rdy_rand = 1'b1; pend.delete();
        for (int j = 0; j < 10; j++) begin
            int dm, dn, dk;
            dm = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            dn = $urandom_range(1, 40);
            dk = $urandom_range(1, 40);
            pulse_start(dm, dn, dk, $urandom_range(0, 3), $urandom_range(0, 3));
            tick($urandom_range(0, 5));
            if (j % 2 == 1) pulse_start($urandom_range(1, 20), 5, 5, $urandom_range(0, 3), 0);
            wait_done(3000);
        end

        rdy_rand = 1'b0; td_mode = 0;
        tick(4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
